// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and divide context for the RV32M mul/div sequencer.
package muldiv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_SIGN = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // Context captured when a long divide is launched, consumed by the sign-fix step.
    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic sel_rem;
    } div_ctx_t;

    // Signed divide ops (DIV, REM) have funct3[0] clear.
    function automatic logic md_is_signed_div(logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider datapath: one quotient bit per step, MSB first.
module muldiv_div_core #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         last_c
);

    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          take;

    // 33-bit trial subtract of the shifted partial remainder.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign take    = shifted[W] | ~diff[W];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= take ? diff[W-1:0] : shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], take};
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign quot   = quo_q;
    assign rem    = rem_q;
    assign last_c = (cnt_q == CW'(W - 1));

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: single-cycle multiply, 32-step divide, pipeline stall and flush abort.
module muldiv_seq #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [3:0]      mulDiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] res
);

    import muldiv_pkg::*;

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            done_q;
    div_ctx_t        ctx_q, ctx_d;

    logic [2:0]        f3;
    logic              accept_c;
    logic              div_load, div_step;
    logic [XLEN-1:0]   quot, rem;
    logic              div_last_c;

    assign f3       = mulDiv_op[2:0];
    assign accept_c = (state_q == ST_IDLE) & start & mulDiv_op[3] & ~flush;

    // Multiplier: sign/zero-extend both operands to 2*XLEN; the low 2*XLEN bits of the product are exact.
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;

    assign a_sx    = op_a[XLEN-1] & ((f3 == MD_MULH) | (f3 == MD_MULHSU));
    assign b_sx    = op_b[XLEN-1] & (f3 == MD_MULH);
    assign prod    = {{XLEN{a_sx}}, op_a} * {{XLEN{b_sx}}, op_b};
    assign mul_res = (f3 == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Divide special cases and operand magnitudes.
    logic            sgn_div, is_rem, b_zero, ovf;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs, special_res;

    assign sgn_div = md_is_signed_div(f3);
    assign is_rem  = f3[1];
    assign b_zero  = (op_b == '0);
    assign ovf     = sgn_div & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
    assign a_neg   = sgn_div & op_a[XLEN-1];
    assign b_neg   = sgn_div & op_b[XLEN-1];
    assign a_abs   = a_neg ? (-op_a) : op_a;
    assign b_abs   = b_neg ? (-op_b) : op_b;

    // Zero divisor: DIV -> all ones, REM -> dividend. Overflow: DIV -> dividend, REM -> 0.
    always_comb begin
        special_res = '0;
        if (b_zero) special_res = is_rem ? op_a : '1;
        else        special_res = is_rem ? '0 : op_a;
    end

    logic [XLEN-1:0] quot_fix, rem_fix;
    assign quot_fix = ctx_q.q_neg ? (-quot) : quot;
    assign rem_fix  = ctx_q.r_neg ? (-rem) : rem;

    muldiv_div_core #(.W(XLEN)) u_div_core (
        .clk      (clk),
        .nrst     (nrst),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_abs),
        .divisor  (b_abs),
        .quot     (quot),
        .rem      (rem),
        .last_c   (div_last_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        ctx_d    = ctx_q;
        div_load = 1'b0;
        div_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (!f3[2]) begin
                        res_d   = mul_res;
                        state_d = ST_FIN;
                    end else if (b_zero || ovf) begin
                        res_d   = special_res;
                        state_d = ST_FIN;
                    end else begin
                        div_load      = 1'b1;
                        ctx_d.q_neg   = a_neg ^ b_neg;
                        ctx_d.r_neg   = a_neg;
                        ctx_d.sel_rem = is_rem;
                        state_d       = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (div_last_c) state_d = ST_SIGN;
            end
            ST_SIGN: begin
                res_d   = ctx_q.sel_rem ? rem_fix : quot_fix;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flush aborts whatever is in flight and leaves res untouched.
        if (flush) begin
            state_d  = ST_IDLE;
            res_d    = res_q;
            div_load = 1'b0;
            div_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            done_q  <= 1'b0;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            done_q  <= (state_d == ST_FIN);
            ctx_q   <= ctx_d;
        end
    end

    assign stall = nrst & (accept_c | (state_q == ST_DIV) | (state_q == ST_SIGN));
    assign done  = done_q;
    assign res   = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases plus randomized ops against an arithmetic model.
module tb_muldiv_seq;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [3:0]  mulDiv_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] res;

    int n_chk;
    int n_fail;

    muldiv_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .mulDiv_op (mulDiv_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural RV32M result, from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Cycle on which done appears, counted from the accept cycle.
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1;
        if (b == 32'h0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op with start held through FIN; check latency, stall length, result, single done pulse.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int          lat;
        int          done_cyc;
        int          stall_cnt;
        logic [31:0] got;
        lat       = ref_lat(f3, a, b);
        done_cyc  = -1;
        stall_cnt = 0;
        got       = 'x;
        @(posedge clk); #1;
        start = 1'b1; mulDiv_op = {1'b1, f3}; op_a = a; op_b = b;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #2;
            end
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = c;
                got      = res;
                break;
            end
        end
        chk({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
        chk({tag, " stall_cycles"}, 32'(stall_cnt), 32'(lat));
        chk({tag, " res"}, got, exp);
        @(posedge clk); #1;
        start = 1'b0; mulDiv_op = 4'h0;
        #1;
        chk({tag, " single_done"}, 32'(done), 32'd0);
        chk({tag, " res_held"}, res, exp);
    endtask

    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rb;
    int          ndone;

    initial begin
        n_chk = 0; n_fail = 0;
        nrst = 1'b0; start = 1'b0; mulDiv_op = 4'h0; op_a = '0; op_b = '0; flush = 1'b0;
        #1;
        chk("rst_stall_low", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_res", res, 32'h0);

        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Invalid op with start, and flush competing with a valid accept: neither stalls nor completes.
        @(posedge clk); #1;
        start = 1'b1; mulDiv_op = 4'b0100; op_a = 32'd9; op_b = 32'd3;
        #1;
        chk("invalid_no_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mulDiv_op = 4'b1100; flush = 1'b1;
        #1;
        chk("flush_blocks_accept", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; mulDiv_op = 4'h0; flush = 1'b0;
        #1;
        chk("no_done_after_block", 32'(done), 32'd0);
        chk("res_kept_after_block", res, 32'h0);

        // Flush in cycle 10 of a DIV; new DIVU 9/3 accepted in cycle 11 completes in cycle 45.
        @(posedge clk); #1;
        start = 1'b1; mulDiv_op = 4'b1100; op_a = 32'd100; op_b = 32'd7;
        #1;
        ndone = 0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #2;
            if (done) ndone++;
        end
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        if (done) ndone++;
        chk("flush_stall_c10", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; mulDiv_op = 4'b1101; op_a = 32'd9; op_b = 32'd3;
        #1;
        chk("flush_no_done", 32'(ndone + int'(done)), 32'd0);
        chk("flush_res_unchanged", res, 32'h0);
        chk("reaccept_stall_c11", 32'(stall), 32'd1);
        begin
            int dc;
            dc = -1;
            for (int c = 12; c < 60; c++) begin
                @(posedge clk); #2;
                if (done) begin
                    dc = c;
                    break;
                end
            end
            chk("post_flush_done_cycle", 32'(dc), 32'd45);
            chk("post_flush_res", res, 32'd3);
        end
        @(posedge clk); #1;
        start = 1'b0; mulDiv_op = 4'h0;

        // Reset pulse mid-DIV clears everything and no done follows.
        @(posedge clk); #1;
        start = 1'b1; mulDiv_op = 4'b1101; op_a = 32'd1000; op_b = 32'd3;
        repeat (6) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_res", res, 32'h0);
        start = 1'b0; mulDiv_op = 4'h0;
        @(posedge clk); #1 nrst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (done) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 16; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, ref_res(rf3, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
